// File: rtl/i2c_target.sv
// I2C target (responder) exposing a 2^REG_BITS x 8 register file over SCL/SDA.
// 7-bit addressing, no clock stretching. SCL is input-only.
// Ports:
//   clock, reset         system clock, asynchronous active-low reset
//   sclIn, sdaIn         pad levels of SCL and SDA
//   sdaOut               1 = release SDA, 0 = pull SDA low
//   busy                 high from an address match until START/STOP
//   wrStrobe             one-cycle pulse per register byte written from the bus
//   wrIndex, wrData      index/data of the last bus write
//   localIndex           local read index
//   localData            combinational mem[localIndex]
module i2c_target #(
    parameter logic [6:0]  ADDRESS  = 7'h1A,
    parameter int unsigned REG_BITS = 4,
    parameter int unsigned FILTER   = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sclIn,
    input  logic                sdaIn,
    output logic                sdaOut,
    output logic                busy,
    output logic                wrStrobe,
    output logic [REG_BITS-1:0] wrIndex,
    output logic [7:0]          wrData,
    input  logic [REG_BITS-1:0] localIndex,
    output logic [7:0]          localData
);

    localparam int unsigned DEPTH = 1 << REG_BITS;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_IGNORE, S_ACK_A, S_PTR,
        S_ACK_P, S_WRITE, S_ACK_W, S_READ, S_MACK
    } state_t;

    logic [1:0]          scl_sync, sda_sync;
    logic [FILTER-1:0]   scl_hist, sda_hist;
    logic                scl_f, sda_f, scl_q, sda_q;
    logic                scl_rise, scl_fall, start_c, stop_c;

    state_t              state, state_d;
    logic [2:0]          bit_cnt, cnt_d;
    logic [7:0]          shift, shift_d;
    logic [REG_BITS-1:0] ptr, ptr_d;
    logic                phase, phase_d;
    logic                rw, rw_d;
    logic                sda_d, busy_d, strobe_d;
    logic [REG_BITS-1:0] idx_d;
    logic [7:0]          data_d;
    logic [7:0]          rx_byte, rd_byte;
    logic [7:0]          mem [DEPTH];

    // Synchronizer plus glitch filter: a new level needs FILTER equal samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], sclIn};
            sda_sync <= {sda_sync[0], sdaIn};
            scl_hist <= FILTER'({scl_hist, scl_sync[1]});
            sda_hist <= FILTER'({sda_hist, sda_sync[1]});
            if (&scl_hist)       scl_f <= 1'b1;
            else if (~|scl_hist) scl_f <= 1'b0;
            if (&sda_hist)       sda_f <= 1'b1;
            else if (~|sda_hist) sda_f <= 1'b0;
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start_c  = ~sda_f & sda_q & scl_f;
    assign stop_c   = sda_f & ~sda_q & scl_f;

    assign rx_byte   = {shift[6:0], sda_f};
    assign rd_byte   = mem[ptr];
    assign localData = mem[localIndex];

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            ptr      <= '0;
            phase    <= 1'b0;
            rw       <= 1'b0;
            sdaOut   <= 1'b1;
            busy     <= 1'b0;
            wrStrobe <= 1'b0;
            wrIndex  <= '0;
            wrData   <= '0;
        end else begin
            state    <= state_d;
            bit_cnt  <= cnt_d;
            shift    <= shift_d;
            ptr      <= ptr_d;
            phase    <= phase_d;
            rw       <= rw_d;
            sdaOut   <= sda_d;
            busy     <= busy_d;
            wrStrobe <= strobe_d;
            wrIndex  <= idx_d;
            wrData   <= data_d;
        end
    end

    // Register file is updated from the registered strobe, so a local read
    // in the strobe cycle still sees the old contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (wrStrobe) begin
            mem[wrIndex] <= wrData;
        end
    end

    // Next-state and output logic. phase marks the second half of an ACK slot
    // (SDA already driven low) or a received controller ACK in MACK.
    always_comb begin
        state_d  = state;
        cnt_d    = bit_cnt;
        shift_d  = shift;
        ptr_d    = ptr;
        phase_d  = phase;
        rw_d     = rw;
        sda_d    = sdaOut;
        busy_d   = busy;
        strobe_d = 1'b0;
        idx_d    = wrIndex;
        data_d   = wrData;

        if (start_c || stop_c) begin
            state_d = start_c ? S_ADDR : S_IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte[7:1] == ADDRESS) begin
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                                phase_d = 1'b0;
                                state_d = S_ACK_A;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                S_ACK_A: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_d   = 1'b0;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = '0;
                            if (rw) begin
                                shift_d = rd_byte;
                                sda_d   = rd_byte[7];
                                state_d = S_READ;
                            end else begin
                                sda_d   = 1'b1;
                                state_d = S_PTR;
                            end
                        end
                    end
                end
                S_PTR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ptr_d   = rx_byte[REG_BITS-1:0];
                            phase_d = 1'b0;
                            state_d = S_ACK_P;
                        end
                    end
                end
                S_ACK_P, S_ACK_W: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_d   = 1'b0;
                            phase_d = 1'b1;
                        end else begin
                            sda_d   = 1'b1;
                            phase_d = 1'b0;
                            cnt_d   = '0;
                            state_d = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            strobe_d = 1'b1;
                            idx_d    = ptr;
                            data_d   = rx_byte;
                            ptr_d    = ptr + REG_BITS'(1);
                            phase_d  = 1'b0;
                            state_d  = S_ACK_W;
                        end
                    end
                end
                // bit_cnt counts bits already presented beyond the MSB.
                S_READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_d   = 1'b1;
                            cnt_d   = '0;
                            phase_d = 1'b0;
                            state_d = S_MACK;
                        end else begin
                            sda_d   = shift[6];
                            shift_d = {shift[6:0], 1'b0};
                            cnt_d   = bit_cnt + 3'd1;
                        end
                    end
                end
                S_MACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr + REG_BITS'(1);
                        if (sda_f) state_d = S_IGNORE;
                        else       phase_d = 1'b1;
                    end else if (scl_fall && phase) begin
                        shift_d = rd_byte;
                        sda_d   = rd_byte[7];
                        cnt_d   = '0;
                        phase_d = 1'b0;
                        state_d = S_READ;
                    end
                end
                default: begin
                    sda_d = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: drives an I2C controller at bit level and checks ACKs,
// read data, busy, write strobes and the local read port against a
// transaction-level model of the register file and pointer.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h1A;
    localparam int Q = 80;  // quarter SCL period, ns

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } wr_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_line;
    logic       sdaOut, busy, wrStrobe;
    logic [3:0] wrIndex;
    logic [7:0] wrData;
    logic [3:0] localIndex = 4'h0;
    logic [7:0] localData;

    assign sda_line = sda_ctrl & sdaOut;

    i2c_target #(.ADDRESS(ADDR), .REG_BITS(4), .FILTER(3)) dut (
        .clock(clock), .reset(reset), .sclIn(scl), .sdaIn(sda_line),
        .sdaOut(sdaOut), .busy(busy), .wrStrobe(wrStrobe),
        .wrIndex(wrIndex), .wrData(wrData),
        .localIndex(localIndex), .localData(localData)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int strobe_cnt = 0;
    bit quiet = 1'b0;

    logic [7:0] ref_mem [16];   // register contents as the bus has defined them
    logic [7:0] view_mem [16];  // what localData must show, cycle accurate
    logic [3:0] ref_ptr = 4'h0;
    wr_t        exp_q [$];
    logic [7:0] txq [$];
    logic [7:0] rdq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = 8'h00;
            view_mem[i] = 8'h00;
        end
        ref_ptr = 4'h0;
        exp_q.delete();
    endtask

    initial forever begin
        @(posedge clock);
        #2 localIndex = 4'($urandom);
    end

    // Per-cycle compare: local read port, quiet SDA, and write strobes.
    always @(negedge clock) begin
        if (reset) begin
            check("localData", 32'(localData), 32'(view_mem[localIndex]));
            if (quiet) check("sdaOut_quiet", 32'(sdaOut), 32'd1);
            if (wrStrobe) begin
                wr_t e;
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL wrStrobe_unexpected: got idx 0x%0h data 0x%0h expected no strobe at %0t",
                             wrIndex, wrData, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wrIndex", 32'(wrIndex), 32'(e.idx));
                    check("wrData", 32'(wrData), 32'(e.data));
                    view_mem[e.idx] = e.data;
                end
            end
        end
    end

    // One SCL clock; optional glitches on SCL and SDA while SCL is high.
    task automatic bit_xfer(input logic b, input logic glitch, output logic line);
        #Q sda_ctrl = b;
        #Q scl = 1'b1;
        if (glitch) begin
            #60 scl = 1'b0;
            #20 scl = 1'b1;
            #40 sda_ctrl = ~b;
            #20 sda_ctrl = b;
            #60;
        end else begin
            #Q;
        end
        line = sda_line;
        #Q scl = 1'b0;
    endtask

    task automatic do_start();
        if (!scl) begin
            #Q sda_ctrl = 1'b1;
            #Q scl = 1'b1;
        end
        #Q sda_ctrl = 1'b0;
        #Q scl = 1'b0;
    endtask

    task automatic do_stop();
        #Q sda_ctrl = 1'b0;
        #Q scl = 1'b1;
        #Q sda_ctrl = 1'b1;
        #(2*Q);
        check("busy_after_stop", 32'(busy), 32'd0);
        check("sda_after_stop", 32'(sdaOut), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], gmask[i], l);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, l);
            b[i] = l;
        end
        bit_xfer(nack, 1'b0, l);
    endtask

    task automatic wr_txn(input logic [6:0] a, input logic [7:0] p);
        logic ack;
        logic match;
        match = (a == ADDR);
        do_start();
        send_byte({a, 1'b0}, 8'h00, ack);
        check("ack_addr_w", 32'(ack), match ? 32'd0 : 32'd1);
        check("busy_addr_w", 32'(busy), 32'(match));
        send_byte(p, 8'h00, ack);
        check("ack_ptr", 32'(ack), match ? 32'd0 : 32'd1);
        if (match) ref_ptr = p[3:0];
        foreach (txq[i]) begin
            if (match) begin
                exp_q.push_back('{idx: ref_ptr, data: txq[i]});
                ref_mem[ref_ptr] = txq[i];
                ref_ptr++;
            end
            send_byte(txq[i], 8'h00, ack);
            check("ack_data", 32'(ack), match ? 32'd0 : 32'd1);
        end
        do_stop();
    endtask

    task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n);
        logic ack;
        logic [7:0] b;
        rdq.delete();
        if (set_ptr) begin
            do_start();
            send_byte({ADDR, 1'b0}, 8'h00, ack);
            check("ack_addr_w", 32'(ack), 32'd0);
            send_byte(p, 8'h00, ack);
            check("ack_ptr", 32'(ack), 32'd0);
            ref_ptr = p[3:0];
        end
        do_start();
        send_byte({ADDR, 1'b1}, 8'h00, ack);
        check("ack_addr_r", 32'(ack), 32'd0);
        check("busy_addr_r", 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, b);
            check("read_data", 32'(b), 32'(ref_mem[ref_ptr]));
            rdq.push_back(b);
            ref_ptr++;
        end
        do_stop();
    endtask

    task automatic abort_txn(input logic [7:0] p, input logic [7:0] bits, input int nb);
        logic ack, l;
        do_start();
        send_byte({ADDR, 1'b0}, 8'h00, ack);
        check("ack_addr_w", 32'(ack), 32'd0);
        send_byte(p, 8'h00, ack);
        check("ack_ptr", 32'(ack), 32'd0);
        ref_ptr = p[3:0];
        for (int k = 0; k < nb; k++) bit_xfer(bits[7-k], 1'b0, l);
        do_stop();
    endtask

    initial begin
        logic       ack, l;
        logic [6:0] a;
        logic [7:0] p;
        int         r, n, s0;

        clear_model();
        #22;
        check("rst_sdaOut", 32'(sdaOut), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wrStrobe", 32'(wrStrobe), 32'd0);
        check("rst_wrIndex", 32'(wrIndex), 32'd0);
        check("rst_wrData", 32'(wrData), 32'd0);
        #20 reset = 1'b1;
        #(4*Q);

        // Write with pointer wrap.
        txq = '{8'h11, 8'h22, 8'h33};
        wr_txn(ADDR, 8'h0F);
        #(2*Q);
        check("t1_strobes", 32'(strobe_cnt), 32'd3);
        check("t1_pending", 32'(exp_q.size()), 32'd0);
        check("t1_model_F", 32'(ref_mem[15]), 32'h11);
        check("t1_model_0", 32'(ref_mem[0]), 32'h22);
        check("t1_model_1", 32'(ref_mem[1]), 32'h33);

        // Read three bytes back through a repeated START.
        rd_txn(1'b1, 8'h0F, 3);
        check("t2_byte0", 32'(rdq[0]), 32'h11);
        check("t2_byte1", 32'(rdq[1]), 32'h22);
        check("t2_byte2", 32'(rdq[2]), 32'h33);
        check("t2_ptr", 32'(ref_ptr), 32'h2);

        // Address mismatch: target stays silent.
        s0 = strobe_cnt;
        quiet = 1'b1;
        txq = '{8'hAA};
        wr_txn(7'h1B, 8'h00);
        quiet = 1'b0;
        check("t3_no_strobe", 32'(strobe_cnt), 32'(s0));

        // Abort a data byte after four bits; mem[5] keeps its value.
        txq = '{8'h3C};
        wr_txn(ADDR, 8'h05);
        s0 = strobe_cnt;
        abort_txn(8'h05, 8'hF0, 4);
        check("t4_no_strobe", 32'(strobe_cnt), 32'(s0));
        rd_txn(1'b1, 8'h05, 1);
        check("t4_mem5", 32'(rdq[0]), 32'h3C);

        // Reset while the target drives a 0 data bit.
        txq = '{8'h0F};
        wr_txn(ADDR, 8'h03);
        #(2*Q);
        do_start();
        send_byte({ADDR, 1'b0}, 8'h00, ack);
        send_byte(8'h03, 8'h00, ack);
        do_start();
        send_byte({ADDR, 1'b1}, 8'h00, ack);
        check("t5_ack", 32'(ack), 32'd0);
        #Q sda_ctrl = 1'b1;
        #Q scl = 1'b1;
        #40;
        check("t5_driven_low", 32'(sda_line), 32'd0);
        reset = 1'b0;
        clear_model();
        #1;
        check("t5_sda_release", 32'(sdaOut), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        #9;
        #40 reset = 1'b1;
        #(4*Q);
        check("t5_wrIndex", 32'(wrIndex), 32'd0);
        check("t5_wrData", 32'(wrData), 32'd0);
        rd_txn(1'b1, 8'h03, 1);
        check("t5_mem3", 32'(rdq[0]), 32'h00);

        // Glitches: SDA on an idle bus, then SCL and SDA inside a data byte.
        #20 sda_ctrl = 1'b0;
        #20 sda_ctrl = 1'b1;
        #(2*Q);
        check("t6_idle_busy", 32'(busy), 32'd0);
        s0 = strobe_cnt;
        do_start();
        send_byte({ADDR, 1'b0}, 8'h00, ack);
        check("t6_ack_addr", 32'(ack), 32'd0);
        send_byte(8'h07, 8'h00, ack);
        check("t6_ack_ptr", 32'(ack), 32'd0);
        ref_ptr = 4'h7;
        exp_q.push_back('{idx: 4'h7, data: 8'hA5});
        ref_mem[7] = 8'hA5;
        ref_ptr++;
        send_byte(8'hA5, 8'hC0, ack);
        check("t6_ack_data", 32'(ack), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        do_stop();
        check("t6_one_strobe", 32'(strobe_cnt), 32'(s0 + 1));
        rd_txn(1'b1, 8'h07, 1);
        check("t6_mem7", 32'(rdq[0]), 32'hA5);

        // Randomized transactions against the model.
        for (int it = 0; it < 20; it++) begin
            r = $urandom_range(0, 9);
            p = 8'($urandom);
            n = $urandom_range(1, 4);
            if (r <= 3) begin
                txq.delete();
                for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
                if (r == 3) begin
                    a = 7'($urandom);
                    if (a == ADDR) a = a ^ 7'h01;
                    quiet = 1'b1;
                end else begin
                    a = ADDR;
                end
                wr_txn(a, p);
                quiet = 1'b0;
            end else if (r <= 6) begin
                rd_txn(1'b1, p, n);
            end else if (r == 7) begin
                rd_txn(1'b0, 8'h00, n);
            end else begin
                abort_txn(p, 8'($urandom), $urandom_range(1, 7));
            end
        end

        #(4*Q);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        l = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C bus target (responder): the counterpart of the system's I2CMaster.
- Exposes a 2^REG_BITS x 8 register file to an external or on-board I2C controller over open-drain SCL/SDA.
- Other on-chip logic gets a combinational read port and a write-event strobe.
- Standard and fast mode; 7-bit addressing; no clock stretching. SCL is input-only.

Parameters:
ADDRESS, 7'h1A, 7-bit target address matched in the address byte.
REG_BITS, 4, register pointer width; register file depth is 2^REG_BITS.
FILTER, 3, number of consecutive equal synchronized samples required to accept a new SCL/SDA level.

Ports:
clock  input  1  system clock, at least 20x the SCL rate
reset  input  1  asynchronous, active-low reset
sclIn  input  1  SCL pad level
sdaIn  input  1  SDA pad level
sdaOut  output  1  1 = release SDA (Z at pad), 0 = drive low; top level builds the tristate
busy  output  1  high from an address match until STOP or START
wrStrobe  output  1  one-cycle pulse per register byte written from the bus
wrIndex  output  REG_BITS  register index of the last bus write
wrData  output  8  data of the last bus write
localIndex  input  REG_BITS  local read index
localData  output  8  combinational mem[localIndex]

Behaviour:
- Reset (reset=0, asynchronous):
  - sdaOut=1, busy=0, wrStrobe=0, wrIndex=0, wrData=0.
  - Pointer=0, all registers=0, state IDLE.
  - Filtered SCL/SDA are preset to 1.
  - Asserting reset mid-transfer releases SDA immediately.
- Input conditioning:
  - 2-flop synchronizer, then the FILTER-sample glitch filter.
  - Edges are detected on the filtered signals: sclRise, sclFall, sdaRise, sdaFall.
- Bus events:
  - START = sdaFall while SCL high.
  - STOP = sdaRise while SCL high.
  - Both are recognised in any state and take priority over bit activity in the same cycle.
  - START enters ADDR with bitCount=0 (repeated START allowed). STOP enters IDLE.
  - On either event: sdaOut=1, busy=0. Pointer is retained.
- Bit timing:
  - SDA is sampled on sclRise.
  - sdaOut changes only on sclFall, in the cycle of that edge.
  - Bytes are MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - On the 8th sclRise, if bits[7:1]==ADDRESS: set busy=1 and go to ACK_A.
    - Otherwise go to IGNORE.
  - IGNORE: sdaOut held 1 until START or STOP.
  - ACK_A: drive sdaOut=0 on the next sclFall; on the following sclFall:
    - R/W=0: release SDA, go to PTR.
    - R/W=1: load shift register with mem[pointer], drive its MSB, go to READ.
  - PTR: shift 8 bits. On the 8th sclRise: pointer <= byte[REG_BITS-1:0] (upper bits ignored), go to ACK_P.
  - ACK_P / ACK_W: drive 0 on the next sclFall, release on the following sclFall, then go to WRITE.
  - WRITE: shift 8 bits. On the 8th sclRise:
    - mem[pointer] <= byte.
    - wrIndex <= pointer, wrData <= byte, wrStrobe=1 for exactly one cycle.
    - pointer <= pointer+1 (wraps modulo 2^REG_BITS).
    - Go to ACK_W.
  - READ:
    - Present the next bit on each sclFall.
    - After the 8th bit's sclFall, release SDA; go to MACK.
  - MACK: sample SDA on sclRise.
    - 0 (ACK): pointer+1 (wrap); on the next sclFall load mem[pointer] and drive its MSB; go to READ.
    - 1 (NACK): pointer+1; go to IGNORE.
- Every byte, including the pointer byte, is ACKed; write data is never NACKed.
- A partial byte terminated by START/STOP is discarded: no register write, no pointer change.
- localData reflects a bus write the cycle after wrStrobe.
- Simultaneous local read and bus write to the same index returns the old value in the strobe cycle.

Test Plan:
1. Write with wrap:
   - Stimulus: START, 0x34, 0x0F, 0x11, 0x22, 0x33, STOP.
   - Response: 5 ACKs (SDA low in each 9th clock); mem[F]=0x11, mem[0]=0x22, mem[1]=0x33.
   - wrStrobe pulses 3 times with (F,11), (0,22), (1,33); busy falls at STOP.
2. Read with repeated START:
   - Stimulus after test 1: START, 0x34, 0x0F, Sr, 0x35, read 3 bytes with ACK, ACK, NACK, STOP.
   - Response: SDA carries 0x11, 0x22, 0x33; sdaOut=1 after NACK; pointer=0x2.
3. Address mismatch:
   - Stimulus: START, 0x36, 0x00, 0xAA, STOP.
   - Response: sdaOut=1 throughout, busy=0, no wrStrobe, registers unchanged.
4. Abort mid-byte:
   - Stimulus: START, 0x34, 0x05, 4 data bits of 0xF0, STOP.
   - Response: no wrStrobe, mem[5] unchanged, state IDLE.
   - A following read from 0x05 returns the old value.
5. Reset during read:
   - Stimulus: drive reset=0 while the target drives a 0 data bit.
   - Response: sdaOut=1 asynchronously (same cycle), all registers 0, busy=0.
6. Glitch rejection:
   - Stimulus (FILTER=3): 2-cycle low glitch on SCL, then a 2-cycle SDA glitch while SCL high.
   - Response: no bit shifted, no START/STOP detected, no state change.
